// File: rtl/oam_ram_asym.sv
// Asymmetric sprite attribute store: narrow lane-wide writes, wide registered entry reads,
// and a sweep engine that clears the whole array after reset or on request.
module oam_ram_asym #(
    parameter int                     WRITE_WIDTH = 16,
    parameter int                     RATIO       = 2,
    parameter int                     READ_DEPTH  = 64,
    parameter logic [WRITE_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int                    READ_WIDTH  = WRITE_WIDTH * RATIO,
    localparam int                    WRITE_DEPTH = READ_DEPTH * RATIO,
    localparam int                    WA          = $clog2(WRITE_DEPTH),
    localparam int                    RA          = $clog2(READ_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_enable,
    input  logic [WA-1:0]          write_addr,
    input  logic [WRITE_WIDTH-1:0] write_data,
    input  logic [RA-1:0]          read_addr,
    output logic [READ_WIDTH-1:0]  read_data,
    input  logic                   clear_start,
    output logic                   busy
);

    localparam int LB = (RATIO > 1) ? $clog2(RATIO) : 0;
    localparam int LW = (LB > 0) ? LB : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [RA-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [READ_WIDTH-1:0] rdata_q, rdata_d;
    logic [READ_WIDTH-1:0] mem_q [READ_DEPTH];

    logic [RA-1:0]         wr_entry;
    logic [LW-1:0]         wr_lane;
    logic                  mem_we;
    logic [RA-1:0]         mem_idx;
    logic [READ_WIDTH-1:0] mem_wdata;

    generate
        if (RATIO == 1) begin : g_single_lane
            assign wr_entry = write_addr;
            assign wr_lane  = '0;
        end else begin : g_multi_lane
            assign wr_entry = write_addr[WA-1:LB];
            assign wr_lane  = write_addr[LB-1:0];
        end
    endgenerate

    // One array write per cycle: the sweep owns the port while clearing, the bus otherwise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_idx   = cnt_q;
        mem_wdata = '0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = cnt_q;
                mem_wdata = {RATIO{CLEAR_VALUE}};
                cnt_d     = cnt_q + RA'(1);
                if (cnt_q == RA'(READ_DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (write_enable) begin
                    mem_we    = 1'b1;
                    mem_idx   = wr_entry;
                    mem_wdata = mem_q[wr_entry];
                    for (int n = 0; n < RATIO; n++) begin
                        if (wr_lane == LW'(n)) begin
                            mem_wdata[n*WRITE_WIDTH +: WRITE_WIDTH] = write_data;
                        end
                    end
                end
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == S_CLEAR);
        // Write-first: a read of the entry being written sees the merged new value.
        if (mem_we && (mem_idx == read_addr)) begin
            rdata_d = mem_wdata;
        end else begin
            rdata_d = mem_q[read_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // The array has no reset; the sweep that follows reset initialises it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    assign read_data = rdata_q;
    assign busy      = busy_q;

endmodule
